// File: rtl/lsu_byte_serial_if.sv
// ============================================================================
// Module  : lsu_byte_serial_if
// Brief   : Core-side request/response and byte-wide memory port bundle for
//           the byte-serial load/store unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_byte_serial_if #(
    parameter int ADDR_W = 32
);
    // Core-side request
    logic              start;
    logic              is_store;
    logic [2:0]        width;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    // Core-side response
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              fault;
    // Byte-wide memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    // Environment side: drives requests and memory responses.
    modport master (
        output start, is_store, width, addr, wdata,
        input  busy, done, rdata, fault,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

    // Load/store unit side.
    modport slave (
        input  start, is_store, width, addr, wdata,
        output busy, done, rdata, fault,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu_byte_serial.sv
// ============================================================================
// Module  : lsu_byte_serial
// Brief   : Byte-serial load/store unit. Runs 1, 2 or 4 little-endian byte
//           transfers over an 8-bit req/ack port, assembles and sign/zero
//           extends load data, serialises store data.
//           Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word
//           requests fault immediately instead of running byte-serially.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_byte_serial #(
    parameter int ADDR_W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lsu_byte_serial_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic              r_is_store;
    logic [2:0]        r_width;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [1:0]        r_last;
    logic [31:0]       r_result;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic              w_accept;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_reject;
    logic              w_byte_ack;
    logic              w_last_ack;
    logic [31:0]       w_result_nx;
    logic [31:0]       w_load_val;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_illegal  = (bus.width[1:0] == 2'b11) || (bus.is_store && bus.width[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.width[1:0] == 2'b01) && bus.addr[0]) ||
                        ((bus.width[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject   = w_illegal || w_misalign;
    assign w_byte_ack = (r_state == S_XFER) && bus.mem_ack;
    assign w_last_ack = w_byte_ack && (r_idx == r_last);

    // Memory port is a pure function of the latched request and byte index,
    // so it stays stable for as long as the memory withholds mem_ack.
    assign bus.mem_addr  = r_addr + ADDR_W'(r_idx);
    assign bus.mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
    assign bus.rdata     = r_rdata;
    assign bus.fault     = r_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        w_state_nx  = r_state;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_state_nx = w_reject ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = r_is_store;
                if (w_last_ack) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.done   = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Result register with the byte arriving this cycle merged in.
    always_comb begin
        w_result_nx = r_result;
        if (!r_is_store) begin
            w_result_nx[{r_idx, 3'b000} +: 8] = bus.mem_rdata;
        end
    end

    // Sign/zero extension of the assembled load; stores return zero.
    always_comb begin
        w_load_val = w_result_nx;
        if (r_is_store) begin
            w_load_val = 32'h0;
        end else begin
            case (r_width[1:0])
                2'b00:   w_load_val = {{24{~r_width[2] & w_result_nx[7]}},  w_result_nx[7:0]};
                2'b01:   w_load_val = {{16{~r_width[2] & w_result_nx[15]}}, w_result_nx[15:0]};
                default: w_load_val = w_result_nx;
            endcase
        end
    end

    // Request latching, byte sequencing and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_width    <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_idx      <= 2'd0;
            r_last     <= 2'd0;
            r_result   <= 32'h0;
            r_rdata    <= 32'h0;
            r_fault    <= 1'b0;
        end else if (w_accept) begin
            r_is_store <= bus.is_store;
            r_width    <= bus.width;
            r_addr     <= bus.addr;
            r_wdata    <= bus.wdata;
            r_idx      <= 2'd0;
            r_result   <= 32'h0;
            case (bus.width[1:0])
                2'b00:   r_last <= 2'd0;
                2'b01:   r_last <= 2'd1;
                default: r_last <= 2'd3;
            endcase
            // A rejected request completes next cycle with a zero result.
            r_fault    <= w_reject;
            if (w_reject) begin
                r_rdata <= 32'h0;
            end
        end else if (w_byte_ack) begin
            r_result <= w_result_nx;
            r_idx    <= r_idx + 2'd1;
            if (w_last_ack) begin
                r_rdata <= w_load_val;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_serial.sv
// ============================================================================
// Module  : tb_lsu_byte_serial
// Brief   : Self-checking bench for lsu_byte_serial: directed vector table,
//           randomized operations against a reference model, reset abort.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_serial;

    localparam int c_MAX_CYC = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_byte_serial_if #(.ADDR_W(32)) bus ();

    lsu_byte_serial #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    int          delay_mode = 0;     // <0: random 0..2 wait cycles per byte
    int          wait_total = 0;
    int          req_cycles = 0;
    logic [40:0] xlog[$];            // {we, addr, wdata} per completed transfer
    logic [40:0] exp_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic        rst_at_edge = 1'b1;
    bit          hit_prev = 0;
    bit          req_prev = 0;
    bit          need_new = 1;
    int          wait_left = 0;
    logic [40:0] lat = '0;

    always @(posedge clk) rst_at_edge <= rst;

    always @(negedge clk) begin
        if (hit_prev && !rst_at_edge) begin
            xlog.push_back(lat);
            if (lat[40]) mem[lat[15:8]] = lat[7:0];
        end
        if (req_prev && !hit_prev && !rst_at_edge)
            chk("mem_stable", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, lat});
        if (bus.mem_req) begin
            req_cycles++;
            if (need_new) begin
                wait_left = (delay_mode < 0) ? int'($urandom_range(0, 2)) : delay_mode;
                need_new  = 0;
            end
            if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[7:0]];
                need_new      = 1;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'($urandom);
                wait_left--;
                wait_total++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            need_new    = 1;
        end
        hit_prev = bus.mem_req && bus.mem_ack;
        req_prev = bus.mem_req;
        lat      = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
    end

    // ---------------- reference model ----------------
    task automatic ref_model(input bit st, input logic [2:0] w, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] erd,
                             output logic eft, output int n);
        int     nb;
        longint v;
        logic [31:0] ai;
        nb  = (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
        eft = (w[1:0] == 2'd3) || (st && w[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if (!eft && (a % nb) != 0) eft = 1'b1;
`endif
        exp_log.delete();
        erd = 32'h0;
        n   = 0;
        if (eft) return;
        n = nb;
        v = 0;
        for (int i = 0; i < nb; i++) begin
            ai = a + i;
            exp_log.push_back({st, ai, wd[8*i +: 8]});
            v += longint'(mem[ai[7:0]]) << (8 * i);
        end
        if (!st) begin
            if (!w[2] && v >= (64'sd1 <<< (8 * nb - 1))) v -= (64'sd1 <<< (8 * nb));
            erd = v[31:0];
        end
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_xfer_count"}, xlog.size(), exp_log.size());
        for (int i = 0; i < xlog.size() && i < exp_log.size(); i++)
            chk({tag, "_xfer"}, xlog[i], exp_log[i]);
    endtask

    // ---------------- one operation ----------------
    task automatic run_op(input bit st, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic ft, output int cyc);
        bus.start    = 1'b1;
        bus.is_store = st;
        bus.width    = w;
        bus.addr     = a;
        bus.wdata    = wd;
        wait_total   = 0;
        req_cycles   = 0;
        xlog.delete();
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < c_MAX_CYC) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) chk("done_timeout", 0, 1);
        chk("busy_in_done", bus.busy, 1'b1);
        rd = bus.rdata;
        ft = bus.fault;
        @(negedge clk);
        chk("done_pulse", bus.done, 1'b0);
        chk("idle_after", bus.busy, 1'b0);
        chk("rdata_hold", bus.rdata, rd);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          st;
        logic [2:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        int          dly;
        logic [31:0] pre;
        logic [31:0] erd;
        bit          eft;
        int          ecyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd, erd;
        logic        ft, eft;
        int          cyc, n;
        bit          st;
        logic [2:0]  w;
        logic [31:0] a, wd, pa;
        bit          seen_done;

        vecs[0] = '{0, 3'd2, 32'h0000_0080, 32'h0,         0, 32'h0000_0058, 32'h0000_0058, 0, 5};
        vecs[1] = '{0, 3'd0, 32'h0000_0010, 32'h0,         0, 32'h0000_0080, 32'hFFFF_FF80, 0, 2};
        vecs[2] = '{0, 3'd4, 32'h0000_0010, 32'h0,         0, 32'h0000_0080, 32'h0000_0080, 0, 2};
        vecs[3] = '{0, 3'd5, 32'h0000_0020, 32'h0,         2, 32'h0000_9234, 32'h0000_9234, 0, 7};
        vecs[4] = '{1, 3'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,         0, 5};
        vecs[5] = '{0, 3'd3, 32'h0000_0040, 32'h0,         0, 32'h0,         32'h0,         1, 1};
        vecs[6] = '{1, 3'd4, 32'h0000_0044, 32'h1234_5678, 0, 32'h0,         32'h0,         1, 1};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[7] = '{0, 3'd2, 32'h0000_0102, 32'h0,         0, 32'h1122_3344, 32'h0,         1, 1};
        vecs[9] = '{1, 3'd1, 32'h0000_0041, 32'h0000_A55A, 0, 32'h0,         32'h0,         1, 1};
`else
        vecs[7] = '{0, 3'd2, 32'h0000_0102, 32'h0,         0, 32'h1122_3344, 32'h1122_3344, 0, 5};
        vecs[9] = '{1, 3'd1, 32'h0000_0041, 32'h0000_A55A, 1, 32'h0,         32'h0,         0, 5};
`endif
        vecs[8] = '{0, 3'd1, 32'h0000_0030, 32'h0,         1, 32'h0000_8001, 32'hFFFF_8001, 0, 5};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.width     = 3'd0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_fault",     bus.fault,     1'b0);
        chk("rst_mem_req",   bus.mem_req,   1'b0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_rdata",     bus.rdata,     32'h0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 4; b++) begin
                pa = vecs[i].a + b;
                if (!vecs[i].st) mem[pa[7:0]] = vecs[i].pre[8*b +: 8];
            end
            delay_mode = vecs[i].dly;
            ref_model(vecs[i].st, vecs[i].w, vecs[i].a, vecs[i].wd, erd, eft, n);
            run_op(vecs[i].st, vecs[i].w, vecs[i].a, vecs[i].wd, rd, ft, cyc);
            chk($sformatf("vec%0d_rdata", i),   rd,  vecs[i].erd);
            chk($sformatf("vec%0d_fault", i),   ft,  vecs[i].eft);
            chk($sformatf("vec%0d_latency", i), cyc, vecs[i].ecyc);
            chk($sformatf("vec%0d_req_cycles", i), req_cycles, vecs[i].eft ? 0 : vecs[i].ecyc - 1);
            chk($sformatf("vec%0d_model_rdata", i), rd, erd);
            cmp_log($sformatf("vec%0d", i));
            if (i == 4) begin
                chk("sw_wrap_b0", mem[8'hFE], 8'hEF);
                chk("sw_wrap_b1", mem[8'hFF], 8'hBE);
                chk("sw_wrap_b2", mem[8'h00], 8'hAD);
                chk("sw_wrap_b3", mem[8'h01], 8'hDE);
            end
        end

        // Randomized operations, back to back
        for (int t = 0; t < 60; t++) begin
            st = 1'($urandom_range(0, 1));
            w  = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            delay_mode = (t % 3 == 0) ? -1 : int'($urandom_range(0, 1));
            ref_model(st, w, a, wd, erd, eft, n);
            run_op(st, w, a, wd, rd, ft, cyc);
            chk("rand_rdata",   rd,  erd);
            chk("rand_fault",   ft,  eft);
            chk("rand_latency", cyc, eft ? 1 : n + 1 + wait_total);
            cmp_log("rand");
        end

        // Reset abort after the second byte of a word load, with a start
        // attempted while busy.
        delay_mode = 0;
        bus.start    = 1'b1;
        bus.is_store = 1'b0;
        bus.width    = 3'd2;
        bus.addr     = 32'h0000_0060;
        @(negedge clk);                       // byte 0 on the bus
        bus.start = 1'b0;
        @(negedge clk);                       // byte 1 on the bus
        bus.start = 1'b1;
        bus.addr  = 32'h0000_0500;
        @(negedge clk);                       // byte 2 on the bus
        chk("abort_latched_addr", bus.mem_addr, 32'h0000_0062);
        chk("abort_busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy0",     bus.busy,      1'b0);
        chk("abort_done0",     bus.done,      1'b0);
        chk("abort_fault0",    bus.fault,     1'b0);
        chk("abort_mem_req0",  bus.mem_req,   1'b0);
        chk("abort_mem_we0",   bus.mem_we,    1'b0);
        chk("abort_rdata0",    bus.rdata,     32'h0);
        chk("abort_mem_addr0", bus.mem_addr,  32'h0);
        chk("abort_wdata0",    bus.mem_wdata, 8'h0);
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.mem_req) seen_done = 1;
        end
        chk("abort_no_done", seen_done, 1'b0);

        // Recovery after abort
        for (int b = 0; b < 4; b++) mem[8'h70 + b] = 8'(8'hA0 + b);
        delay_mode = -1;
        ref_model(1'b0, 3'd2, 32'h0000_0070, 32'h0, erd, eft, n);
        run_op(1'b0, 3'd2, 32'h0000_0070, 32'h0, rd, ft, cyc);
        chk("recover_rdata", rd, 32'hA3A2_A1A0);
        chk("recover_fault", ft, 1'b0);
        cmp_log("recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lsu_byte_serial.md
# lsu_byte_serial

Byte-serial load/store unit between the core control FSM and the byte-wide data memory. It takes an effective address from the ALU plus the RV32I `funct3` width field and runs 1, 2 or 4 little-endian byte transfers over an 8-bit req/ack memory port. For loads it assembles the result, zero- or sign-extends it, and returns a 32-bit word for register writeback. For stores it serialises the low bytes of the write data.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the address, and of `addr` and `mem_addr`.

Ports:
- `clk` in 1: single clock. All state changes on the posedge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request pulse. Accepted only when `busy`=0.
- `is_store` in 1: 1 selects store, 0 selects load. Sampled with `start`.
- `width` in 3: RV32I `funct3`. Sampled with `start`.
  - `[1:0]`: 0 = byte, 1 = half, 2 = word.
  - `[2]`: unsigned load.
- `addr` in `ADDR_W`: effective byte address. Sampled with `start`.
- `wdata` in 32: store data. Sampled with `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: load result. Valid from `done`; held until the next accepted `start`.
- `fault` out 1: illegal or misaligned request. Valid with `done`.
- `mem_req` out 1: byte transfer request.
- `mem_we` out 1: byte write enable.
- `mem_addr` out `ADDR_W`: byte address.
- `mem_wdata` out 8: byte write data.
- `mem_ack` in 1: transfer complete. May be high in the same cycle `mem_req` rises.
- `mem_rdata` in 8: read byte. Valid when `mem_ack`=1.

## Operation
- State machine: IDLE, XFER, DONE.
- IDLE:
  - `start`=1 latches `is_store`, `width`, `addr` and `wdata`.
  - Sets byte count N: 1, 2 or 4 from `width[1:0]`.
  - Clears byte index k and the internal result register.
  - Goes to XFER.
  - Illegal width: `width[1:0]`=3, or a store with `width[2]`=1. Goes directly to DONE with `fault`=1, `rdata`=0 and no memory traffic.
- XFER:
  - `mem_req`=1, `mem_we`=`is_store`.
  - `mem_addr` = `addr` + k, modulo 2^`ADDR_W`; wrap-around is permitted.
  - `mem_wdata` = `wdata[8k +: 8]`.
  - All `mem_*` outputs stay stable until the cycle in which `mem_ack`=1.
  - On `mem_ack`:
    - Load: capture `mem_rdata` into result byte k.
    - k increments.
    - If k = N−1, go to DONE.
    - Otherwise stay in XFER, with `mem_req` still high, the next address and the next byte.
- DONE:
  - `done`=1 for exactly one cycle, `mem_req`=0.
  - `rdata` updated from the result register:
    - `width[2]`=0: sign-extend from bit 8N−1.
    - `width[2]`=1: zero-extend.
    - Store: 0.
  - Returns to IDLE.
- `busy` = (state ≠ IDLE). `busy` is 1 in DONE; `start` in DONE is ignored.
- `start` while `busy` is ignored, and the latched operands are unchanged.
- Byte order is little-endian: byte k at `addr`+k maps to bits `[8k +: 8]`.

## Timing
- Reset: the edge with `rst`=1 forces IDLE.
  - `busy`, `done`, `fault`, `mem_req` and `mem_we` = 0.
  - `rdata`, `mem_addr` and `mem_wdata` = 0.
- `rst` mid-transfer aborts the operation. `mem_req` is 0 from the cycle after that edge, and no `done` is produced.
- `rst` and `start` in the same cycle: `rst` wins.
- `start` accepted at edge T0:
  - `mem_req` is high from T0+1.
  - With `mem_ack` always 1, bytes transfer in cycles T0+1 … T0+N, and `done` is high in cycle T0+N+1.
- Each low cycle of `mem_ack` adds exactly one cycle of latency.
- Back-to-back operations: the earliest next `start` is accepted on the edge that ends the `done` cycle. The minimum issue interval is N+2 cycles.
- Illegal width: `done`=1 in the cycle after `start`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned request completes like an illegal width: `done` the cycle after `start`, `fault`=1, `rdata`=0, no memory traffic.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- `LSU_MISALIGN_TRAP_EN` not defined: misaligned accesses run normally byte-serially. `fault` is set only for illegal widths.

## Test plan
- LW, `addr`=0x80, memory bytes 0x80..0x83 = 58 00 00 00, `mem_ack` tied 1 → `done` at T0+5, `rdata`=0x00000058, `fault`=0.
- LB and LBU, byte 0x80 at 0x10 → LB returns `rdata`=0xFFFFFF80; LBU returns 0x00000080.
- LHU at 0x20, bytes 34 92, `mem_ack` delayed 2 cycles per byte → `rdata`=0x00009234, `done` at T0+7, `mem_addr` stable across each wait.
- SW, `wdata`=0xDEADBEEF, `addr`=0xFFFFFFFE → writes EF, BE, AD, DE to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap-around); `mem_we`=1 throughout; `rdata`=0.
- Illegal width 3, and separately LW at 0x102 → width 3 gives `fault`=1 with no `mem_req`. LW at 0x102 with macro defined: `fault`=1, no `mem_req`. Without the macro: 4 transfers, `fault`=0.
- `rst` pulsed after the 2nd byte of an LW, plus `start` asserted while `busy` → abort with no `done`, all outputs 0 next cycle; the `start` while `busy` leaves the latched `addr` unchanged.
